// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised Moore sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_HUNT  = 2'd1,
    S_MATCH = 2'd2
  } state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_det_shift_hist.sv
// Serial history shift register with a saturating fill counter.
// clear and shift together restart the history with the incoming bit as its first entry.
module seq_det_shift_hist #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             clear,
  input  logic             bit_in,
  output logic [PAT_W-1:0] hist,
  output logic             full,
  output logic             full_nxt
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_base;
  logic [FILL_W-1:0] fill_q, fill_d, fill_base;

  always_comb begin
    hist_base = clear ? '0 : hist_q;
    fill_base = clear ? '0 : fill_q;
    hist_d    = hist_base;
    fill_d    = fill_base;
    if (shift) begin
      hist_d = {hist_base[PAT_W-2:0], bit_in};
      if (fill_base != FILL_MAX) fill_d = fill_base + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist     = hist_q;
  assign full     = (fill_q == FILL_MAX);
  assign full_nxt = (fill_d == FILL_MAX);

endmodule

// File: rtl/moore_seq_det_param.sv
// Parametrised Moore serial sequence detector with runtime-loadable pattern.
// Define SEQ_DET_MATCH_CNT_EN to add the saturating match counter (match_cnt, cnt_clr).
module moore_seq_det_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_data,
`ifdef SEQ_DET_MATCH_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             out
);

  state_e           state;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] cand;
  logic             full, full_nxt;
  logic             take, clear, ready, hit;
  logic             unused_hist_msb;

  // A pattern load drops any bit presented alongside it.
  assign take  = in_valid && !pat_load;
  assign clear = pat_load || (state == S_MATCH && !overlap);
  assign cand  = {hist[PAT_W-2:0], in};
  assign unused_hist_msb = hist[PAT_W-1];

  seq_det_shift_hist #(
    .PAT_W(PAT_W)
  ) u_hist (
    .clk     (clk),
    .reset   (reset),
    .shift   (take),
    .clear   (clear),
    .bit_in  (in),
    .hist    (hist),
    .full    (full),
    .full_nxt(full_nxt)
  );

  // History is comparable once this bit completes the fill, or it was already full and kept.
  always_comb begin
    ready = 1'b0;
    unique case (state)
      S_FILL:  ready = full_nxt;
      S_HUNT:  ready = full;
      S_MATCH: ready = full && overlap;
      default: ready = 1'b0;
    endcase
  end

  assign hit = take && ready && (cand == pat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FILL;
      pat   <= PATTERN;
      out   <= 1'b0;
    end else if (pat_load) begin
      state <= S_FILL;
      pat   <= pat_data;
      out   <= 1'b0;
    end else if (hit) begin
      state <= S_MATCH;
      out   <= 1'b1;
    end else begin
      out <= 1'b0;
      unique case (state)
        S_FILL:  if (take && full_nxt) state <= S_HUNT;
        S_HUNT:  state <= S_HUNT;
        S_MATCH: state <= overlap ? S_HUNT : S_FILL;
        default: state <= S_FILL;
      endcase
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= hit ? CNT_W'(1) : '0;
    end else if (hit && match_cnt != '1) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_moore_seq_det_param.sv
// Scoreboard bench for moore_seq_det_param; covers the counter when SEQ_DET_MATCH_CNT_EN is set.
module tb_moore_seq_det_param;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in, overlap, pat_load, cnt_clr;
  logic [PAT_W-1:0] pat_data;
  logic             out;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  always #5 clk = ~clk;

  moore_seq_det_param #(
    .PAT_W  (PAT_W),
    .PATTERN(4'b1101),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in       (in),
    .overlap  (overlap),
    .pat_load (pat_load),
    .pat_data (pat_data),
`ifdef SEQ_DET_MATCH_CNT_EN
    .cnt_clr  (cnt_clr),
    .match_cnt(match_cnt),
`endif
    .out      (out)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         pulses;
  logic       exp_q[$];
  int         cnt_q[$];

  // Reference model state: 0 fill, 1 hunt, 2 match.
  int         m_st, m_fill, m_cnt;
  logic [3:0] m_hist, m_pat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_fill = 0;
    m_hist = '0;
    m_pat  = 4'b1101;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic ld, input logic [3:0] pd,
                            input logic clr);
    bit entered;
    if (reset) begin
      model_reset();
      return;
    end
    if (ld) begin
      m_pat  = pd;
      m_hist = '0;
      m_fill = 0;
      m_st   = 0;
    end else if (m_st == 2) begin
      if (overlap) begin
        if (v) m_hist = {m_hist[2:0], b};
        m_st = (v && m_hist == m_pat) ? 2 : 1;
      end else begin
        m_hist = v ? {3'b000, b} : 4'b0000;
        m_fill = v ? 1 : 0;
        m_st   = 0;
      end
    end else if (v) begin
      m_hist = {m_hist[2:0], b};
      if (m_fill < 4) m_fill++;
      if (m_fill == 4) m_st = (m_hist == m_pat) ? 2 : 1;
    end
    entered = (m_st == 2);
    if (clr) m_cnt = entered ? 1 : 0;
    else if (entered && m_cnt < 3) m_cnt++;
  endtask

  task automatic step(input logic v, input logic b, input logic ld = 1'b0,
                      input logic [3:0] pd = 4'b0000, input logic clr = 1'b0);
    in_valid = v;
    in       = b;
    pat_load = ld;
    pat_data = pd;
    cnt_clr  = clr;
    model_step(v, b, ld, pd, clr);
    exp_q.push_back(m_st == 2);
    cnt_q.push_back(m_cnt);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      check("out", {31'b0, out}, {31'b0, exp_q.pop_front()});
`ifdef SEQ_DET_MATCH_CNT_EN
      check("match_cnt", 32'(match_cnt), 32'(cnt_q.pop_front()));
`else
      void'(cnt_q.pop_front());
`endif
    end
    if (out === 1'b1) pulses++;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i] == 8'h31);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    exp_q.delete();
    cnt_q.delete();
    @(posedge clk);
    #1;
    check("rst_out", {31'b0, out}, 0);
    reset  = 1'b0;
    pulses = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in       = 1'b0;
    overlap  = 1'b1;
    pat_load = 1'b0;
    pat_data = '0;
    cnt_clr  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {31'b0, out}, 0);
`ifdef SEQ_DET_MATCH_CNT_EN
    check("reset_cnt", 32'(match_cnt), 0);
`endif
    reset  = 1'b0;
    pulses = 0;

    // Overlapping detection
    send("1101101");
    idle(2);
    check("t1_pulses", pulses, 2);

    // Non-overlapping detection
    overlap = 1'b0;
    do_reset();
    send("1101101");
    idle(2);
    check("t2a_pulses", pulses, 1);
    do_reset();
    send("11011101");
    idle(2);
    check("t2b_pulses", pulses, 2);

    // Reset mid-sequence discards partial history
    overlap = 1'b1;
    do_reset();
    send("110");
    reset = 1'b1;
    step(1'b1, 1'b1);
    reset = 1'b0;
    idle(1);
    check("t3a_pulses", pulses, 0);
    send("1101");
    idle(1);
    check("t3b_pulses", pulses, 1);

    // Pattern load drops the simultaneous bit
    overlap = 1'b0;
    do_reset();
    step(1'b1, 1'b1, 1'b1, 4'b0110);
    send("0110");
    idle(1);
    check("t4a_pulses", pulses, 1);
    pulses = 0;
    send("1101");
    idle(2);
    check("t4b_pulses", pulses, 0);

    // Gapped valid stream, fixed gaps then random gaps
    overlap = 1'b1;
    for (int g = 0; g < 5; g++) begin
      do_reset();
      for (int k = 0; k < 4; k++) begin
        step(1'b1, (k != 2));
        idle((g < 4) ? g : int'($urandom_range(0, 3)));
      end
      idle(2);
      check("t5_pulses", pulses, 1);
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    // Counter saturation, clear, and clear coinciding with a match
    do_reset();
    send("1101101101101101");
    idle(1);
    check("t6_pulses", pulses, 5);
    check("t6_sat", 32'(match_cnt), 3);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    check("t6_clr", 32'(match_cnt), 0);
    send("110");
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    check("t6_clr_hit", 32'(match_cnt), 1);
    idle(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
